btb_assoc: RTL and testbench

// - Parametrised N-way set-associative branch target buffer for the lc3b fetch stage.
// - Combinational lookup on the fetch PC returns hit, target and a taken/not-taken prediction.
// - Prediction comes from a 2-bit saturating counter per entry.
// - Resolved branches from execute update, allocate or train entries; victims use tree pseudo-LRU.
// - A sequential flush FSM invalidates the whole array, one set per cycle.

---
 rtl/btb_assoc_pkg.sv | 27 ++
 rtl/btb_assoc_if.sv | 26 ++
 rtl/btb_plru.sv | 43 ++++
 rtl/comparator.sv | 12 +
 rtl/btb_assoc.sv | 160 ++++++++++++++++
 tb/tb_btb_assoc.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared types for the set-associative branch target buffer: counter type,
// flush FSM states and the saturating counter step.
package btb_assoc_pkg;

    localparam int unsigned PC_W = 16;

    typedef logic [1:0] lc3b_btb_ctr;
    localparam lc3b_btb_ctr BTB_CTR_INIT = 2'b10;

    typedef enum logic {
        BTB_IDLE,
        BTB_FLUSH
    } btb_state_t;

    // Two-bit saturating counter: up on taken, down on not taken.
    function automatic lc3b_btb_ctr ctr_step(input lc3b_btb_ctr ctr, input logic taken);
        lc3b_btb_ctr res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-side lookup and execute-side update/flush bundle of the BTB.
interface btb_assoc_if;
    import btb_assoc_pkg::*;

    logic [PC_W-1:0] read_pc;
    logic            hit;
    logic [PC_W-1:0] predicted_pc;
    logic            predict_taken;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            flush;
    logic            busy;

    modport master (
        output read_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        input  hit, predicted_pc, predict_taken, busy
    );

    modport slave (
        input  read_pc, upd_valid, upd_pc, upd_target, upd_taken, flush,
        output hit, predicted_pc, predict_taken, busy
    );

endinterface

// File: rtl/btb_plru.sv
// Tree pseudo-LRU: victim selection and touch update for one set.
// A tree bit of 0 steers the victim search to the lower half.
module btb_plru #(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-2:0]         tree_i,
    input  logic [$clog2(WAYS)-1:0] touch_way_i,
    output logic [WAYS-2:0]         tree_c_o,
    output logic [$clog2(WAYS)-1:0] victim_c_o
);

    localparam int unsigned WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] vic_node;
    logic [WAY_W-1:0] tch_node;
    logic             vic_dir;
    logic             tch_dir;

    // Follow the tree bits from the root down to a leaf.
    always_comb begin
        victim_c_o = '0;
        vic_node   = '0;
        vic_dir    = 1'b0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            vic_dir                  = tree_i[vic_node];
            victim_c_o[WAY_W-1-l]    = vic_dir;
            vic_node                 = WAY_W'({vic_node, vic_dir} + 1);
        end
    end

    // Point every node on the touched way's path away from it.
    always_comb begin
        tree_c_o = tree_i;
        tch_node = '0;
        tch_dir  = 1'b0;
        for (int l = 0; l < int'(WAY_W); l++) begin
            tch_dir            = touch_way_i[WAY_W-1-l];
            tree_c_o[tch_node] = ~tch_dir;
            tch_node           = WAY_W'({tch_node, tch_dir} + 1);
        end
    end

endmodule

// File: rtl/comparator.sv
// Generic equality comparator used for tag match.
module comparator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_c_o
);

    assign eq_c_o = (a_i == b_i);

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with 2-bit direction counters,
// tree PLRU replacement and a one-set-per-cycle flush sequencer.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SETS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    btb_assoc_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 15 - IDX_W;
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned NODES = WAYS - 1;

    logic [SETS-1:0]  valid_q  [WAYS];
    logic [TAG_W-1:0] tag_q    [WAYS][SETS];
    logic [PC_W-1:0]  target_q [WAYS][SETS];
    lc3b_btb_ctr      ctr_q    [WAYS][SETS];
    logic [NODES-1:0] plru_q   [SETS];

    btb_state_t       state_q, state_d;
    logic [IDX_W-1:0] set_cnt_q, set_cnt_d;

    logic [IDX_W-1:0] rd_idx, up_idx;
    logic [TAG_W-1:0] rd_tag, up_tag;
    logic [WAYS-1:0]  rd_tag_eq, up_tag_eq, rd_match, up_match;
    logic             rd_hit, up_hit, any_invalid, upd_en, idle;
    logic [WAY_W-1:0] rd_way, up_way, inv_way, plru_victim, alloc_way, touch_way;
    logic [NODES-1:0] plru_nxt;
    logic             unused_pc_lsb;

    assign rd_idx = bus.read_pc[IDX_W:1];
    assign rd_tag = bus.read_pc[15:IDX_W+1];
    assign up_idx = bus.upd_pc[IDX_W:1];
    assign up_tag = bus.upd_pc[15:IDX_W+1];
    assign unused_pc_lsb = bus.read_pc[0] ^ bus.upd_pc[0];

    for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
        comparator #(.WIDTH(TAG_W)) u_rd_cmp (
            .a_i    (tag_q[w][rd_idx]),
            .b_i    (rd_tag),
            .eq_c_o (rd_tag_eq[w])
        );
        comparator #(.WIDTH(TAG_W)) u_up_cmp (
            .a_i    (tag_q[w][up_idx]),
            .b_i    (up_tag),
            .eq_c_o (up_tag_eq[w])
        );
        assign rd_match[w] = valid_q[w][rd_idx] & rd_tag_eq[w];
        assign up_match[w] = valid_q[w][up_idx] & up_tag_eq[w];
    end

    // Lowest matching / lowest invalid way wins.
    always_comb begin
        rd_hit      = 1'b0;
        rd_way      = '0;
        up_hit      = 1'b0;
        up_way      = '0;
        any_invalid = 1'b0;
        inv_way     = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (rd_match[w]) begin
                rd_hit = 1'b1;
                rd_way = WAY_W'(w);
            end
            if (up_match[w]) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!valid_q[w][up_idx]) begin
                any_invalid = 1'b1;
                inv_way     = WAY_W'(w);
            end
        end
    end

    assign idle      = (state_q == BTB_IDLE);
    assign alloc_way = any_invalid ? inv_way : plru_victim;
    assign touch_way = up_hit ? up_way : alloc_way;
    assign upd_en    = bus.upd_valid & idle & ~bus.flush & (up_hit | bus.upd_taken);

    btb_plru #(.WAYS(WAYS)) u_plru (
        .tree_i      (plru_q[up_idx]),
        .touch_way_i (touch_way),
        .tree_c_o    (plru_nxt),
        .victim_c_o  (plru_victim)
    );

    assign bus.hit           = rd_hit & idle;
    assign bus.predicted_pc  = bus.hit ? target_q[rd_way][rd_idx] : '0;
    assign bus.predict_taken = bus.hit & ctr_q[rd_way][rd_idx][1];
    assign bus.busy          = (state_q == BTB_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BTB_IDLE;
            set_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            set_cnt_q <= set_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        case (state_q)
            BTB_IDLE: begin
                if (bus.flush) begin
                    state_d   = BTB_FLUSH;
                    set_cnt_d = '0;
                end
            end
            BTB_FLUSH: begin
                if (set_cnt_q == IDX_W'(SETS - 1)) state_d = BTB_IDLE;
                else                               set_cnt_d = set_cnt_q + 1'b1;
            end
            default: state_d = BTB_IDLE;
        endcase
    end

    // Valid, counter and PLRU state; cleared by reset, valid/PLRU also by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                valid_q[w] <= '0;
                for (int s = 0; s < int'(SETS); s++) ctr_q[w][s] <= '0;
            end
            for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
        end else if (state_q == BTB_FLUSH) begin
            for (int w = 0; w < int'(WAYS); w++) valid_q[w][set_cnt_q] <= 1'b0;
            plru_q[set_cnt_q] <= '0;
        end else if (upd_en) begin
            plru_q[up_idx] <= plru_nxt;
            if (up_hit) begin
                ctr_q[up_way][up_idx] <= ctr_step(ctr_q[up_way][up_idx], bus.upd_taken);
            end else begin
                valid_q[alloc_way][up_idx] <= 1'b1;
                ctr_q[alloc_way][up_idx]   <= BTB_CTR_INIT;
            end
        end
    end

    // Tag and target payload carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (upd_en && bus.upd_taken) begin
            if (up_hit) begin
                target_q[up_way][up_idx] <= bus.upd_target;
            end else begin
                tag_q[alloc_way][up_idx]    <= up_tag;
                target_q[alloc_way][up_idx] <= bus.upd_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (WAYS=4, SETS=8): lookup, training,
// replacement, flush and reset-during-flush.
module tb_btb_assoc;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    btb_assoc_if bus ();

    btb_assoc #(.WAYS(4), .SETS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = tk;
        @(negedge clk);
        bus.upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic eh,
                        input logic [15:0] ep, input logic et);
        bus.read_pc = pc;
        #1;
        check({tag, ".hit"},   32'(bus.hit),           32'(eh));
        check({tag, ".pc"},    32'(bus.predicted_pc),  32'(ep));
        check({tag, ".taken"}, 32'(bus.predict_taken), 32'(et));
    endtask

    task automatic probe(input logic [15:0] pc, output logic h);
        bus.read_pc = pc;
        #1;
        h = bus.hit;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic h0, h1, h2;
        int   busy_cnt;

        rst_n          = 1'b0;
        bus.read_pc    = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        bus.flush      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        look("rst", 16'h3000, 1'b0, 16'h0000, 1'b0);
        check("rst.busy", 32'(bus.busy), 32'd0);

        // Allocate, counter starts at weakly taken
        upd(16'h3004, 16'h3100, 1'b1);
        look("alloc", 16'h3004, 1'b1, 16'h3100, 1'b1);

        // Three not-taken: 10 -> 01 -> 00 -> 00, target kept
        upd(16'h3004, 16'hDEAD, 1'b0);
        look("nt1", 16'h3004, 1'b1, 16'h3100, 1'b0);
        upd(16'h3004, 16'hDEAD, 1'b0);
        look("nt2", 16'h3004, 1'b1, 16'h3100, 1'b0);
        upd(16'h3004, 16'hDEAD, 1'b0);
        look("nt3", 16'h3004, 1'b1, 16'h3100, 1'b0);
        // Back up from 00 to 01: still not taken
        upd(16'h3004, 16'h3100, 1'b1);
        look("up1", 16'h3004, 1'b1, 16'h3100, 1'b0);

        // Fill set 5 with four taken branches
        upd(16'h100A, 16'hA001, 1'b1);
        upd(16'h200A, 16'hA002, 1'b1);
        upd(16'h300A, 16'hA003, 1'b1);
        upd(16'h400A, 16'hA004, 1'b1);
        look("fill0", 16'h100A, 1'b1, 16'hA001, 1'b1);
        look("fill3", 16'h400A, 1'b1, 16'hA004, 1'b1);

        // Retrain way 0 (counter 10 -> 11, new target), then allocate a fifth
        upd(16'h100A, 16'h1111, 1'b1);
        look("retrain", 16'h100A, 1'b1, 16'h1111, 1'b1);
        upd(16'h500A, 16'hA005, 1'b1);
        look("evict.w0", 16'h100A, 1'b1, 16'h1111, 1'b1);
        look("evict.new", 16'h500A, 1'b1, 16'hA005, 1'b1);
        probe(16'h200A, h0);
        probe(16'h300A, h1);
        probe(16'h400A, h2);
        check("evict.one_gone", 32'(int'(h0) + int'(h1) + int'(h2)), 32'd2);

        // Saturation at 11: taken again, then one not-taken leaves 10
        upd(16'h100A, 16'h1111, 1'b1);
        upd(16'h100A, 16'h1111, 1'b0);
        look("sat", 16'h100A, 1'b1, 16'h1111, 1'b1);

        // Miss and not taken allocates nothing
        upd(16'h700C, 16'h7777, 1'b0);
        look("miss_nt", 16'h700C, 1'b0, 16'h0000, 1'b0);

        // Same-cycle read and allocate: lookup sees old contents
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 16'h600E;
        bus.upd_target = 16'h6666;
        bus.upd_taken  = 1'b1;
        look("rw.before", 16'h600E, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        look("rw.after", 16'h600E, 1'b1, 16'h6666, 1'b1);

        // Flush with a coincident update: flush wins
        @(negedge clk);
        bus.flush      = 1'b1;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 16'h7008;
        bus.upd_target = 16'h7000;
        bus.upd_taken  = 1'b1;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.upd_valid = 1'b0;
        bus.read_pc   = 16'h3004;
        busy_cnt      = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i == 0) begin
                check("flush.hit_masked", 32'(bus.hit), 32'd0);
                check("flush.pc_masked", 32'(bus.predicted_pc), 32'd0);
                bus.upd_valid  = 1'b1;
                bus.upd_pc     = 16'h2008;
                bus.upd_target = 16'h2222;
                bus.upd_taken  = 1'b1;
            end else begin
                bus.upd_valid = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        check("flush.busy_cycles", 32'(busy_cnt), 32'd8);
        look("flush.a", 16'h3004, 1'b0, 16'h0000, 1'b0);
        look("flush.b", 16'h100A, 1'b0, 16'h0000, 1'b0);
        look("flush.c", 16'h500A, 1'b0, 16'h0000, 1'b0);
        look("flush.d", 16'h600E, 1'b0, 16'h0000, 1'b0);
        look("flush.drop_coinc", 16'h7008, 1'b0, 16'h0000, 1'b0);
        look("flush.drop_busy", 16'h2008, 1'b0, 16'h0000, 1'b0);

        // Reset in the middle of a flush
        upd(16'h600E, 16'h6666, 1'b1);
        upd(16'h3004, 16'h3100, 1'b1);
        look("pre_rst", 16'h600E, 1'b1, 16'h6666, 1'b1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("midflush.busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midflush.rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.busy", 32'(bus.busy), 32'd0);
        look("post_rst.set7", 16'h600E, 1'b0, 16'h0000, 1'b0);
        look("post_rst.set2", 16'h3004, 1'b0, 16'h0000, 1'b0);
        upd(16'h3004, 16'h3200, 1'b1);
        look("post_rst.alloc", 16'h3004, 1'b1, 16'h3200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
